load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have port Req  input  1  core access request, sampled only in IDLE.
REQ-004 SHALL have port WE  input  1  1 = store, 0 = load.
REQ-005 SHALL have port Funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-006 SHALL have port Addr  input  32  byte address.
REQ-007 SHALL have port Store_Data  input  32  store data, right-aligned.
REQ-008 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port Load_Data  output  32  extended load result.
REQ-011 SHALL have port Misaligned  output  1  fault flag, valid with Done.
REQ-012 SHALL have port Mem_Address  output  32  word address to Data_Memory, equal to {Addr[31:2],2'b00}.
REQ-013 SHALL have port Mem_WD  output  32  write word to Data_Memory.
REQ-014 SHALL have port Mem_Write  output  1  Data_Memory write enable.
REQ-015 SHALL have port Mem_RD  input  32  Data_Memory read word, combinational from Mem_Address.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-017 In IDLE with Req=1, SHALL latch WE, Funct3, Addr, and Store_Data.
REQ-018 Legal requests SHALL transition as follows: load -> READ; SW -> WRITE; SB/SH -> READ.
REQ-019 Misaligned or illegal requests SHALL go directly to DONE.
REQ-020 Misaligned SHALL mean H/HU with Addr[0]=1, or W with Addr[1:0]!=00.
REQ-021 Illegal SHALL mean Funct3 in {011,110,111}, or a store with Funct3[2]=1.
REQ-022 Misaligned or illegal requests SHALL produce no Mem_Write, Load_Data=0, and Misaligned=1 for misalignment only.
REQ-023 In READ, Mem_Address SHALL be driven and Mem_RD SHALL be captured at the cycle-end edge; loads -> DONE, SB/SH -> WRITE.
REQ-024 In WRITE, Mem_Write SHALL be 1 for exactly one cycle, then the FSM SHALL go to DONE.
REQ-025 For SW, Mem_WD SHALL be Store_Data.
REQ-026 For SB, Mem_WD SHALL be the captured word with byte lane Addr[1:0] replaced by Store_Data[7:0]; lanes are little-endian, lane 0 = bits 7:0.
REQ-027 For SH, Mem_WD SHALL be the captured word with half lane Addr[1] replaced by Store_Data[15:0].
REQ-028 Loads SHALL select the lane as above; B/H SHALL sign-extend, BU/HU SHALL zero-extend, W SHALL pass through.
REQ-029 In DONE, Done SHALL be 1 and the FSM SHALL return to IDLE on the next edge.
REQ-030 Load_Data SHALL hold its value until the next load or fault completes; stores SHALL leave Load_Data unchanged.
REQ-031 Latency from Req edge to Done SHALL be: load 2 cycles, SW 2, SB/SH 3, fault 1.
REQ-032 Req SHALL be ignored while Busy=1, including in DONE; no queuing.
REQ-033 Mem_Write SHALL never be asserted outside WRITE.

Reset
REQ-034 RST=1 at an edge SHALL force IDLE from any state, aborting with no Done pulse.
REQ-035 RST SHALL clear Busy=0, Done=0, Load_Data=0, Misaligned=0, Mem_Address=0, Mem_WD=0, and Mem_Write=0.
REQ-036 RST SHALL take priority over Req in the same cycle.
REQ-037 A request arriving in the first cycle after RST deasserts SHALL be accepted.

Verification
REQ-038 SW: Addr=0xFFD0, Store_Data=100 -> Mem_Write=1 for one cycle with Mem_Address=0xFFD0 and Mem_WD=100; Done at +2.
REQ-039 SB: Addr=0xFFD1, Store_Data=0xAB, memory word 0x11223344 -> Mem_WD=0x1122AB44; Done at +3.
REQ-040 Sign extension: LB at 0xFFD3 on word 0x80FFFFFF -> Load_Data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-041 Misalignment: LW at 0xFFD2 -> Done at +1 with Misaligned=1, Load_Data=0, no Mem_Write; SH at 0xFFD1 -> Misaligned=1, memory unchanged.
REQ-042 Busy rule: Req pulsed again during READ of an LW -> ignored, exactly one Done.
REQ-043 Reset: RST asserted in the READ cycle of an SB -> no Mem_Write, no Done, all outputs 0 next cycle; a new LW then completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: byte/half/word load-store sequencer in front of a word-wide data memory.
// Sub-word stores use read-modify-write; faults finish in one cycle without touching memory.
module load_store_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        WE,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] Store_Data,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Load_Data,
  output logic        Misaligned,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_WD,
  output logic        Mem_Write,
  input  logic [31:0] Mem_RD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] sdata_q, sdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mis_q, mis_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mem_write_q, mem_write_d;

  logic        req_illegal, req_misal;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext, st_merge;

  assign req_illegal = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) || (WE && Funct3[2]);
  assign req_misal   = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                       ((Funct3 == 3'b010) && (Addr[1:0] != 2'b00));

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = Mem_RD[7:0];
      2'd1:    rd_byte = Mem_RD[15:8];
      2'd2:    rd_byte = Mem_RD[23:16];
      default: rd_byte = Mem_RD[31:24];
    endcase
    rd_half = off_q[1] ? Mem_RD[31:16] : Mem_RD[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'd0, rd_byte};
      3'b101:  ld_ext = {16'd0, rd_half};
      default: ld_ext = Mem_RD;
    endcase
    st_merge = Mem_RD;
    if (funct3_q[0]) begin
      if (off_q[1]) st_merge[31:16] = sdata_q;
      else          st_merge[15:0]  = sdata_q;
    end else begin
      case (off_q)
        2'd0:    st_merge[7:0]   = sdata_q[7:0];
        2'd1:    st_merge[15:8]  = sdata_q[7:0];
        2'd2:    st_merge[23:16] = sdata_q[7:0];
        default: st_merge[31:24] = sdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    sdata_d     = sdata_q;
    load_data_d = load_data_q;
    mis_d       = mis_q;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    case (state_q)
      IDLE: begin
        if (Req) begin
          we_d       = WE;
          funct3_d   = Funct3;
          off_d      = Addr[1:0];
          sdata_d    = Store_Data[15:0];
          mem_addr_d = {Addr[31:2], 2'b00};
          if (req_illegal || req_misal) begin
            state_d     = DONE;
            load_data_d = 32'd0;
            mis_d       = req_misal && !req_illegal;
          end else begin
            mis_d = 1'b0;
            if (WE && (Funct3 == 3'b010)) begin
              state_d  = WRITE;
              mem_wd_d = Store_Data;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (we_q) begin
          mem_wd_d = st_merge;
          state_d  = WRITE;
        end else begin
          load_data_d = ld_ext;
          state_d     = DONE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the state being entered.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_write_d = (state_d == WRITE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      sdata_q     <= 16'd0;
      load_data_q <= 32'd0;
      mis_q       <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wd_q    <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      sdata_q     <= sdata_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Load_Data   = load_data_q;
  assign Misaligned  = mis_q;
  assign Mem_Address = mem_addr_q;
  assign Mem_WD      = mem_wd_q;
  assign Mem_Write   = mem_write_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: directed-vector bench with a one-word memory model behind the unit.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] Store_Data = 32'd0;
  logic        Busy, Done, Misaligned, Mem_Write;
  logic [31:0] Load_Data, Mem_Address, Mem_WD, Mem_RD;

  logic [31:0] mem_word = 32'd0;
  logic        pl_en = 1'b0;
  logic [31:0] pl_data = 32'd0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          total = 0;
  int          bad = 0;
  int          wr0, dn0;

  load_store_unit dut (
    .CLK(CLK), .RST(RST), .Req(Req), .WE(WE), .Funct3(Funct3), .Addr(Addr),
    .Store_Data(Store_Data), .Busy(Busy), .Done(Done), .Load_Data(Load_Data),
    .Misaligned(Misaligned), .Mem_Address(Mem_Address), .Mem_WD(Mem_WD),
    .Mem_Write(Mem_Write), .Mem_RD(Mem_RD)
  );

  always #5 CLK = ~CLK;

  // All test addresses fall in word 0xFFD0, so a single memory word suffices.
  assign Mem_RD = mem_word;
  always @(posedge CLK) begin
    if (Mem_Write)  mem_word <= Mem_WD;
    else if (pl_en) mem_word <= pl_data;
    wr_cnt   <= wr_cnt + int'(Mem_Write);
    done_cnt <= done_cnt + int'(Done);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] d);
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, Done}, 32'd0);
    chk({tag, "_ld"}, Load_Data, 32'd0);
    chk({tag, "_mis"}, {31'd0, Misaligned}, 32'd0);
    chk({tag, "_maddr"}, Mem_Address, 32'd0);
    chk({tag, "_mwd"}, Mem_WD, 32'd0);
    chk({tag, "_mwr"}, {31'd0, Mem_Write}, 32'd0);
  endtask

  // Issues one request and returns in the first cycle Done is seen (bounded wait).
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int exp_lat);
    int n;
    WE = we; Funct3 = f3; Addr = a; Store_Data = sd; Req = 1'b1;
    wr0 = wr_cnt; dn0 = done_cnt;
    tick();
    Req = 1'b0;
    n = 1;
    while (!Done && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  initial begin
    tick();
    tick();
    chk_reset("rst");

    // SW issued in the very first cycle after reset release.
    RST = 1'b0;
    WE = 1'b1; Funct3 = 3'b010; Addr = 32'hFFD0; Store_Data = 32'd100; Req = 1'b1;
    wr0 = wr_cnt;
    tick();
    Req = 1'b0;
    chk("sw_mwr", {31'd0, Mem_Write}, 32'd1);
    chk("sw_maddr", Mem_Address, 32'hFFD0);
    chk("sw_mwd", Mem_WD, 32'd100);
    chk("sw_busy", {31'd0, Busy}, 32'd1);
    chk("sw_nodone", {31'd0, Done}, 32'd0);
    tick();
    chk("sw_done", {31'd0, Done}, 32'd1);
    chk("sw_mwr_off", {31'd0, Mem_Write}, 32'd0);
    chk("sw_mem", mem_word, 32'd100);
    chk("sw_wrs", wr_cnt - wr0, 32'd1);
    tick();
    chk("sw_idle_busy", {31'd0, Busy}, 32'd0);
    chk("sw_idle_done", {31'd0, Done}, 32'd0);

    poke(32'h11223344);
    do_req("sb", 1'b1, 3'b000, 32'hFFD1, 32'h000000AB, 3);
    chk("sb_mem", mem_word, 32'h1122AB44);
    chk("sb_wrs", wr_cnt - wr0, 32'd1);
    chk("sb_ld_keep", Load_Data, 32'd0);
    tick();

    poke(32'h80FFFFFF);
    do_req("lb", 1'b0, 3'b000, 32'hFFD3, 32'd0, 2);
    chk("lb_data", Load_Data, 32'hFFFFFF80);
    chk("lb_mis", {31'd0, Misaligned}, 32'd0);
    chk("lb_maddr", Mem_Address, 32'hFFD0);
    tick();
    do_req("lbu", 1'b0, 3'b100, 32'hFFD3, 32'd0, 2);
    chk("lbu_data", Load_Data, 32'h00000080);
    tick();
    do_req("lh", 1'b0, 3'b001, 32'hFFD2, 32'd0, 2);
    chk("lh_data", Load_Data, 32'hFFFF80FF);
    tick();
    do_req("lhu", 1'b0, 3'b101, 32'hFFD0, 32'd0, 2);
    chk("lhu_data", Load_Data, 32'h0000FFFF);
    tick();
    do_req("lw", 1'b0, 3'b010, 32'hFFD0, 32'd0, 2);
    chk("lw_data", Load_Data, 32'h80FFFFFF);
    tick();

    do_req("sh", 1'b1, 3'b001, 32'hFFD2, 32'h00001234, 3);
    chk("sh_mem", mem_word, 32'h1234FFFF);
    chk("sh_ld_keep", Load_Data, 32'h80FFFFFF);
    tick();

    do_req("lw_mis", 1'b0, 3'b010, 32'hFFD2, 32'd0, 1);
    chk("lw_mis_flag", {31'd0, Misaligned}, 32'd1);
    chk("lw_mis_ld", Load_Data, 32'd0);
    chk("lw_mis_wrs", wr_cnt - wr0, 32'd0);
    tick();
    do_req("sh_mis", 1'b1, 3'b001, 32'hFFD1, 32'h0000BEEF, 1);
    chk("sh_mis_flag", {31'd0, Misaligned}, 32'd1);
    tick();
    chk("sh_mis_mem", mem_word, 32'h1234FFFF);
    chk("sh_mis_wrs", wr_cnt - wr0, 32'd0);

    do_req("lw2", 1'b0, 3'b010, 32'hFFD0, 32'd0, 2);
    chk("lw2_data", Load_Data, 32'h1234FFFF);
    tick();
    do_req("ill_ld", 1'b0, 3'b011, 32'hFFD0, 32'd0, 1);
    chk("ill_ld_mis", {31'd0, Misaligned}, 32'd0);
    chk("ill_ld_data", Load_Data, 32'd0);
    tick();
    do_req("ill_st", 1'b1, 3'b100, 32'hFFD0, 32'h000000CC, 1);
    chk("ill_st_mis", {31'd0, Misaligned}, 32'd0);
    tick();
    chk("ill_st_mem", mem_word, 32'h1234FFFF);
    chk("ill_st_wrs", wr_cnt - wr0, 32'd0);

    // Req held high through READ and DONE of an LW must not start a second access.
    dn0 = done_cnt;
    WE = 1'b0; Funct3 = 3'b010; Addr = 32'hFFD0; Req = 1'b1;
    tick();
    chk("busy_read", {31'd0, Busy}, 32'd1);
    tick();
    chk("busy_done", {31'd0, Done}, 32'd1);
    tick();
    Req = 1'b0;
    chk("busy_idle", {31'd0, Busy}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("busy_one_done", done_cnt - dn0, 32'd1);

    // Reset in the READ cycle of an SB aborts it silently.
    poke(32'h55667788);
    wr0 = wr_cnt; dn0 = done_cnt;
    WE = 1'b1; Funct3 = 3'b000; Addr = 32'hFFD1; Store_Data = 32'h000000EE; Req = 1'b1;
    tick();
    Req = 1'b0;
    RST = 1'b1;
    tick();
    chk_reset("abort");
    RST = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_wrs", wr_cnt - wr0, 32'd0);
    chk("abort_dones", done_cnt - dn0, 32'd0);
    chk("abort_mem", mem_word, 32'h55667788);
    do_req("lw_after", 1'b0, 3'b010, 32'hFFD0, 32'd0, 2);
    chk("lw_after_data", Load_Data, 32'h55667788);
    tick();

    // Reset wins over a simultaneous request.
    RST = 1'b1; Req = 1'b1;
    tick();
    RST = 1'b0; Req = 1'b0;
    chk("rst_prio_busy", {31'd0, Busy}, 32'd0);
    chk("rst_prio_ld", Load_Data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
